// File: rtl/mem_access_ctrl_if.sv
// Bundles the CPU-side request/response handshake and the external memory bus
// of the memory access controller.
interface mem_access_ctrl_if;
  logic [31:0] A;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        abort;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_wait;

  modport slave (
    input  A, req, wr, size, wdata, mem_rdata, mem_wait,
    output ready, done, abort, rdata, mem_addr, mem_req, mem_we, mem_be, mem_wdata
  );

  modport master (
    output A, req, wr, size, wdata, mem_rdata, mem_wait,
    input  ready, done, abort, rdata, mem_addr, mem_req, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-access load/store controller: byte/halfword/word accesses onto a
// 32-bit little-endian bus with wait states, alignment checks and timeout abort.
module mem_access_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus
);

  localparam int CW_RAW = $clog2(MAX_WAIT + 1);
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   is_illegal = 1'b0;
      2'b01:   is_illegal = lo[0];
      2'b10:   is_illegal = (lo != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   lane_enables = 4'b0001 << lo;
      2'b01:   lane_enables = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   replicate = {4{wd[7:0]}};
      2'b01:   replicate = {2{wd[15:0]}};
      default: replicate = wd;
    endcase
  endfunction

  function automatic logic [31:0] select_lane(input logic [1:0] sz, input logic [1:0] lo,
                                              input logic [31:0] rd);
    logic [31:0] shifted;
    shifted = rd >> {lo, 3'b000};
    case (sz)
      2'b00:   select_lane = {24'h000000, shifted[7:0]};
      2'b01:   select_lane = lo[1] ? {16'h0000, rd[31:16]} : {16'h0000, rd[15:0]};
      default: select_lane = rd;
    endcase
  endfunction

  state_t          state_r, state_next_s;
  logic [1:0]      addr_lo_r;
  logic [1:0]      size_r;
  logic            wr_r;
  logic [CW-1:0]   cnt_r;
  logic            ready_r, done_r, abort_r, mem_req_r, mem_we_r;
  logic [31:0]     rdata_r, mem_addr_r, mem_wdata_r;
  logic [3:0]      mem_be_r;
  logic            accept_s, illegal_s, done_set_s, abort_set_s, capture_s, cnt_inc_s;
  logic            wr_next_s;

  assign illegal_s = is_illegal(bus.size, bus.A[1:0]);
  assign wr_next_s = accept_s ? bus.wr : wr_r;

  // Next-state and one-shot event decode
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    done_set_s   = 1'b0;
    abort_set_s  = 1'b0;
    capture_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          accept_s = 1'b1;
          if (illegal_s) begin
            state_next_s = RESP;
            abort_set_s  = 1'b1;
          end else begin
            state_next_s = ACCESS;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (!bus.mem_wait) begin
          state_next_s = RESP;
          done_set_s   = 1'b1;
          capture_s    = ~wr_r;
        end else if (cnt_r == CW'(MAX_WAIT)) begin
          state_next_s = RESP;
          abort_set_s  = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_lo_r   <= 2'b00;
      size_r      <= 2'b00;
      wr_r        <= 1'b0;
      cnt_r       <= '0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      abort_r     <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 4'b0000;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      rdata_r     <= 32'h0000_0000;
    end else begin
      state_r   <= state_next_s;
      ready_r   <= (state_next_s == IDLE);
      mem_req_r <= (state_next_s == ACCESS);
      mem_we_r  <= (state_next_s == ACCESS) & wr_next_s;
      done_r    <= done_set_s;
      abort_r   <= abort_set_s;
      if (accept_s) begin
        addr_lo_r <= bus.A[1:0];
        size_r    <= bus.size;
        wr_r      <= bus.wr;
        cnt_r     <= '0;
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
      // Bus drive values only change on a legal accept, so they hold for the whole access
      if (accept_s && !illegal_s) begin
        mem_addr_r  <= {bus.A[31:2], 2'b00};
        mem_be_r    <= lane_enables(bus.size, bus.A[1:0]);
        mem_wdata_r <= replicate(bus.size, bus.wdata);
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_be_r    <= mem_be_r;
        mem_wdata_r <= mem_wdata_r;
      end
      if (capture_s) begin
        rdata_r <= select_lane(size_r, addr_lo_r, bus.mem_rdata);
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign bus.ready     = ready_r;
  assign bus.done      = done_r;
  assign bus.abort     = abort_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_be    = mem_be_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with hand-computed expectations.
module tb_mem_access_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.MAX_WAIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", bus.ready); end
    checks++; if (bus.done !== 1'b0 || bus.abort !== 1'b0) begin errors++; $display("FAIL rst_pulses got done=%0b abort=%0b exp=0", bus.done, bus.abort); end
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_memctl got req=%0b we=%0b exp=0", bus.mem_req, bus.mem_we); end
    checks++; if (bus.mem_be !== 4'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_bus got be=%h addr=%h wd=%h exp=0", bus.mem_be, bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_word_load();
    bus.A = 32'h0000_0100; bus.size = 2'b10; bus.wr = 1'b0; bus.req = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF; bus.mem_wait = 1'b0;
    step();
    bus.req = 1'b0;
    checks++; if (bus.mem_req !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL wl_access got req=%0b ready=%0b exp=1,0", bus.mem_req, bus.ready); end
    checks++; if (bus.mem_addr !== 32'h100 || bus.mem_be !== 4'hF || bus.mem_we !== 1'b0) begin errors++; $display("FAIL wl_bus got addr=%h be=%h we=%0b exp=100,f,0", bus.mem_addr, bus.mem_be, bus.mem_we); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL wl_early_done got=%0b exp=0", bus.done); end
    step();
    checks++; if (bus.done !== 1'b1 || bus.abort !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL wl_done got done=%0b abort=%0b req=%0b exp=1,0,0", bus.done, bus.abort, bus.mem_req); end
    checks++; if (bus.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wl_rdata got=%h exp=deadbeef", bus.rdata); end
    step();
    checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin errors++; $display("FAIL wl_idle got done=%0b ready=%0b exp=0,1", bus.done, bus.ready); end
  endtask

  task automatic test_byte_load();
    bus.A = 32'h0000_0203; bus.size = 2'b00; bus.wr = 1'b0; bus.req = 1'b1;
    bus.mem_rdata = 32'hAABB_CCDD; bus.mem_wait = 1'b0;
    step();
    bus.req = 1'b0;
    checks++; if (bus.mem_be !== 4'b1000 || bus.mem_addr !== 32'h200) begin errors++; $display("FAIL bl_bus got be=%b addr=%h exp=1000,200", bus.mem_be, bus.mem_addr); end
    step();
    checks++; if (bus.done !== 1'b1 || bus.rdata !== 32'h0000_00AA) begin errors++; $display("FAIL bl_rdata got done=%0b rdata=%h exp=1,000000aa", bus.done, bus.rdata); end
    step();
  endtask

  task automatic test_half_store_wait();
    bus.A = 32'h0000_0302; bus.size = 2'b01; bus.wr = 1'b1; bus.wdata = 32'h1234_5678;
    bus.req = 1'b1; bus.mem_wait = 1'b1;
    step();
    bus.req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'b1100 || bus.mem_wdata !== 32'h5678_5678 || bus.mem_addr !== 32'h300)
        begin errors++; $display("FAIL hs_stable cyc=%0d got req=%0b we=%0b be=%b wd=%h addr=%h exp=1,1,1100,56785678,300", i, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr); end
      checks++; if (bus.done !== 1'b0 || bus.abort !== 1'b0) begin errors++; $display("FAIL hs_early cyc=%0d got done=%0b abort=%0b exp=0", i, bus.done, bus.abort); end
      if (i == 3) bus.mem_wait = 1'b0;
      step();
    end
    checks++; if (bus.done !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL hs_done got done=%0b req=%0b we=%0b exp=1,0,0", bus.done, bus.mem_req, bus.mem_we); end
    checks++; if (bus.rdata !== 32'h0000_00AA) begin errors++; $display("FAIL hs_rdata_hold got=%h exp=000000aa", bus.rdata); end
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [3] = '{32'h0000_0101, 32'h0000_0301, 32'h0000_0400};
    logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      bus.A = addrs[i]; bus.size = sizes[i]; bus.wr = 1'b0; bus.req = 1'b1;
      step();
      bus.req = 1'b0;
      checks++; if (bus.abort !== 1'b1 || bus.done !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL ill_abort idx=%0d got abort=%0b done=%0b req=%0b exp=1,0,0", i, bus.abort, bus.done, bus.mem_req); end
      step();
      checks++; if (bus.abort !== 1'b0 || bus.ready !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL ill_recover idx=%0d got abort=%0b ready=%0b req=%0b exp=0,1,0", i, bus.abort, bus.ready, bus.mem_req); end
    end
  endtask

  task automatic test_timeout();
    int aborts;
    aborts = 0;
    bus.A = 32'h0000_0400; bus.size = 2'b10; bus.wr = 1'b0; bus.req = 1'b1;
    bus.mem_wait = 1'b1; bus.mem_rdata = 32'h1111_1111;
    step();
    bus.req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus.mem_req !== 1'b1) begin checks++; errors++; $display("FAIL to_req cyc=%0d got=%0b exp=1", i, bus.mem_req); end
      if (bus.abort === 1'b1) aborts++;
      step();
    end
    checks++; if (bus.abort !== 1'b1 || bus.done !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_abort got abort=%0b done=%0b req=%0b exp=1,0,0", bus.abort, bus.done, bus.mem_req); end
    checks++; if (bus.rdata !== 32'h0000_00AA) begin errors++; $display("FAIL to_rdata got=%h exp=000000aa", bus.rdata); end
    step();
    if (bus.abort === 1'b1) aborts++;
    checks++; if (aborts !== 0 || bus.ready !== 1'b1) begin errors++; $display("FAIL to_once got extra=%0d ready=%0b exp=0,1", aborts, bus.ready); end
    bus.mem_wait = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    bus.A = 32'h0000_0500; bus.size = 2'b10; bus.wr = 1'b1; bus.wdata = 32'hCAFE_0001;
    bus.req = 1'b1; bus.mem_wait = 1'b1;
    step();
    bus.req = 1'b0;
    step();
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rm_pre got req=%0b exp=1", bus.mem_req); end
    reset = 1'b1;
    step();
    checks++; if (bus.mem_req !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.abort !== 1'b0) begin errors++; $display("FAIL rm_drop got req=%0b ready=%0b done=%0b abort=%0b exp=0,1,0,0", bus.mem_req, bus.ready, bus.done, bus.abort); end
    reset = 1'b0; bus.mem_wait = 1'b0;
    step();
    checks++; if (bus.done !== 1'b0 || bus.abort !== 1'b0 || bus.ready !== 1'b1) begin errors++; $display("FAIL rm_after got done=%0b abort=%0b ready=%0b exp=0,0,1", bus.done, bus.abort, bus.ready); end
  endtask

  task automatic test_back_to_back();
    bus.A = 32'h0000_0600; bus.size = 2'b10; bus.wr = 1'b0; bus.req = 1'b1;
    bus.mem_rdata = 32'h0102_0304; bus.mem_wait = 1'b0;
    step();
    bus.A = 32'h0000_0706; bus.size = 2'b01;
    checks++; if (bus.mem_addr !== 32'h600 || bus.mem_be !== 4'hF) begin errors++; $display("FAIL bb_first got addr=%h be=%h exp=600,f", bus.mem_addr, bus.mem_be); end
    step();
    bus.mem_rdata = 32'hCAFE_BABE;
    checks++; if (bus.done !== 1'b1 || bus.rdata !== 32'h0102_0304) begin errors++; $display("FAIL bb_first_done got done=%0b rdata=%h exp=1,01020304", bus.done, bus.rdata); end
    step();
    checks++; if (bus.ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL bb_ignore got ready=%0b req=%0b done=%0b exp=1,0,0", bus.ready, bus.mem_req, bus.done); end
    step();
    bus.req = 1'b0;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h704 || bus.mem_be !== 4'b1100) begin errors++; $display("FAIL bb_second got req=%0b addr=%h be=%b exp=1,704,1100", bus.mem_req, bus.mem_addr, bus.mem_be); end
    step();
    checks++; if (bus.done !== 1'b1 || bus.rdata !== 32'h0000_CAFE) begin errors++; $display("FAIL bb_half_rdata got done=%0b rdata=%h exp=1,0000cafe", bus.done, bus.rdata); end
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.A = 32'h0; bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.wdata = 32'h0;
    bus.mem_rdata = 32'h0; bus.mem_wait = 1'b0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store_wait();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
